moore_seq_gen: RTL and testbench



---
 rtl/moore_seq_pkg.sv | 26 ++
 rtl/seq_piso.sv | 27 ++
 rtl/moore_seq_gen.sv | 125 ++++++++++++
 tb/tb_moore_seq_gen.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/moore_seq_pkg.sv
// Shared types and constants for the moore_seq_gen serial frame generator.
package moore_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE0 = 3'd1,
        ST_PRE1 = 3'd2,
        ST_PRE2 = 3'd3,
        ST_DATA = 3'd4,
        ST_PAR  = 3'd5,
        ST_GAP  = 3'd6
    } state_t;

    localparam int unsigned PRE_LEN = 3;
    localparam logic [PRE_LEN-1:0] PREAMBLE = 3'b101;

    // Clamped to 1 so a 1-bit payload still gets a legal counter width.
    function automatic int unsigned bit_cnt_w(input int unsigned data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

    function automatic int unsigned gap_cnt_w(input int unsigned gap_len);
        return $clog2(gap_len + 1);
    endfunction

endpackage

// File: rtl/seq_piso.sv
// Parallel-in/serial-out shift register; shifts left, MSB is the serial output.
module seq_piso #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] data_in,
    output logic              msb
);

    logic [DATA_W-1:0] r_shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
        end else if (load) begin
            r_shreg <= data_in;
        end else if (shift) begin
            r_shreg <= r_shreg << 1;
        end
    end

    assign msb = r_shreg[DATA_W-1];

endmodule

// File: rtl/moore_seq_gen.sv
// Moore serial frame generator: preamble 101, payload MSB first, optional
// even parity, then GAP_LEN idle zeros.
module moore_seq_gen
    import moore_seq_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter bit          PARITY_EN = 1'b1,
    parameter int unsigned GAP_LEN   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready,
    output logic              x,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = bit_cnt_w(DATA_W);
    localparam int unsigned GAP_W = gap_cnt_w(GAP_LEN);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_par;
    logic             w_load;
    logic             w_shift;
    logic             w_msb;

    assign w_load  = (r_state == ST_IDLE) && valid_in;
    assign w_shift = (r_state == ST_DATA);

    seq_piso #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .shift   (w_shift),
        .data_in (data_in),
        .msb     (w_msb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Counters are preloaded on the edge that enters their state, so the
    // terminal test in that state is a simple compare against zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_par     <= 1'b0;
        end else begin
            if (w_load) begin
                r_par <= ^data_in;
            end
            if (r_state == ST_PRE2) begin
                r_bit_cnt <= BIT_LAST;
            end else if (r_state == ST_DATA && r_bit_cnt != '0) begin
                r_bit_cnt <= r_bit_cnt - 1'b1;
            end
            if (w_next == ST_GAP && r_state != ST_GAP) begin
                r_gap_cnt <= GAP_LAST;
            end else if (r_state == ST_GAP && r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        ready  = 1'b0;
        busy   = 1'b1;
        done   = 1'b0;
        x      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
                if (valid_in) w_next = ST_PRE0;
            end
            ST_PRE0: begin
                x      = PREAMBLE[PRE_LEN-1];
                w_next = ST_PRE1;
            end
            ST_PRE1: begin
                x      = PREAMBLE[PRE_LEN-2];
                w_next = ST_PRE2;
            end
            ST_PRE2: begin
                x      = PREAMBLE[PRE_LEN-3];
                w_next = ST_DATA;
            end
            ST_DATA: begin
                x = w_msb;
                if (r_bit_cnt == '0) w_next = PARITY_EN ? ST_PAR : ST_GAP;
            end
            ST_PAR: begin
                x      = r_par;
                w_next = ST_GAP;
            end
            ST_GAP: begin
                if (r_gap_cnt == '0) begin
                    done   = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: begin
                busy   = 1'b0;
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_moore_seq_gen.sv
// Directed bench for moore_seq_gen: default DUT plus a no-parity variant.
module tb_moore_seq_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_a, x_a, busy_a, done_a;
    logic       ready_b, x_b, busy_b, done_b;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    always #5 clk = ~clk;

    moore_seq_gen u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready    (ready_a),
        .x        (x_a),
        .busy     (busy_a),
        .done     (done_a)
    );

    moore_seq_gen #(
        .DATA_W    (8),
        .PARITY_EN (1'b0),
        .GAP_LEN   (2)
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready    (ready_b),
        .x        (x_b),
        .busy     (busy_b),
        .done     (done_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic ex, input logic er,
                           input logic eb, input logic ed);
        check_val({tag, ".x"},     32'(x_a),     32'(ex));
        check_val({tag, ".ready"}, 32'(ready_a), 32'(er));
        check_val({tag, ".busy"},  32'(busy_a),  32'(eb));
        check_val({tag, ".done"},  32'(done_a),  32'(ed));
    endtask

    task automatic check_b(input string tag, input logic ex, input logic er,
                           input logic eb, input logic ed);
        check_val({tag, ".bx"},     32'(x_b),     32'(ex));
        check_val({tag, ".bready"}, 32'(ready_b), 32'(er));
        check_val({tag, ".bbusy"},  32'(busy_b),  32'(eb));
        check_val({tag, ".bdone"},  32'(done_b),  32'(ed));
    endtask

    // Accepts w, then walks the frame; pa/pb hold the expected bits MSB first.
    task automatic frame(input string tag, input logic [7:0] w,
                         input logic [31:0] pa, input int unsigned la,
                         input logic [31:0] pb, input int unsigned lb,
                         input bit use_b, input bit toggle);
        int unsigned last;
        last = (use_b && lb > la) ? lb : la;
        valid_in = 1'b1;
        data_in  = w;
        tick();
        valid_in = 1'b0;
        for (int unsigned i = 0; i <= last; i++) begin
            if (i != 0) tick();
            if (i < la)
                check_a($sformatf("%s[%0d]", tag, i), pa[la-1-i], 1'b0, 1'b1, i == la - 1);
            else if (i == la)
                check_a($sformatf("%s[%0d]", tag, i), 1'b0, 1'b1, 1'b0, 1'b0);
            if (use_b) begin
                if (i < lb)
                    check_b($sformatf("%s[%0d]", tag, i), pb[lb-1-i], 1'b0, 1'b1, i == lb - 1);
                else if (i == lb)
                    check_b($sformatf("%s[%0d]", tag, i), 1'b0, 1'b1, 1'b0, 1'b0);
            end
            if (toggle) begin
                valid_in = (i + 1 < la) ? i[0] : 1'b0;
                data_in  = 8'h3C ^ 8'(i);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] b2b;
        rst      = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        do_reset();
        check_a("reset", 1'b0, 1'b1, 1'b0, 1'b0);
        check_b("reset", 1'b0, 1'b1, 1'b0, 1'b0);

        for (int unsigned i = 0; i < 20; i++) begin
            tick();
            check_a($sformatf("idle[%0d]", i), 1'b0, 1'b1, 1'b0, 1'b0);
        end

        // 0xA5: 101 10100101 0 00
        frame("a5", 8'hA5, 32'b10110100101000, 14, 32'd0, 0, 1'b0, 1'b0);

        // 0x07: with parity 101 00000111 1 00, without 101 00000111 00
        do_reset();
        frame("w07", 8'h07, 32'b10100000111100, 14, 32'b1010000011100, 13, 1'b1, 1'b0);

        // Back-to-back: FF frame, one idle zero, then 00 frame
        do_reset();
        b2b = 32'b10111111111000_0_10100000000000;
        valid_in = 1'b1;
        data_in  = 8'hFF;
        tick();
        data_in  = 8'h00;
        for (int unsigned i = 0; i < 29; i++) begin
            if (i != 0) tick();
            check_a($sformatf("b2b[%0d]", i), b2b[28-i], i == 14, i != 14,
                    i == 13 || i == 28);
            if (i == 15) valid_in = 1'b0;
        end
        tick();
        check_a("b2b.end", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check_a("b2b.end2", 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset during 4th data bit of 0xC3: 101 1100...
        do_reset();
        valid_in = 1'b1;
        data_in  = 8'hC3;
        tick();
        valid_in = 1'b0;
        for (int unsigned i = 0; i < 7; i++) begin
            logic [6:0] pre;
            pre = 7'b1011100;
            if (i != 0) tick();
            check_a($sformatf("c3[%0d]", i), pre[6-i], 1'b0, 1'b1, 1'b0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_a("abort", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int unsigned i = 0; i < 10; i++) begin
            tick();
            check_a($sformatf("abort_idle[%0d]", i), 1'b0, 1'b1, 1'b0, 1'b0);
        end
        // 0x81: 101 10000001 0 00
        frame("w81", 8'h81, 32'b10110000001000, 14, 32'd0, 0, 1'b0, 1'b0);

        // rst and valid_in together: reset wins
        rst      = 1'b1;
        valid_in = 1'b1;
        data_in  = 8'hFF;
        tick();
        rst      = 1'b0;
        valid_in = 1'b0;
        check_a("rstvalid", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check_a("rstvalid.n", 1'b0, 1'b1, 1'b0, 1'b0);

        // 0x5A with inputs churning mid-frame: 101 01011010 0 00
        frame("w5a", 8'h5A, 32'b10101011010000, 14, 32'd0, 0, 1'b0, 1'b1);
        // 0x3C afterwards: 101 00111100 0 00
        frame("w3c", 8'h3C, 32'b10100111100000, 14, 32'd0, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
